// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: byte width common to receiver, FIFO and transmitter.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the RX FIFO.
// One write port and one registered read port.
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              rx_Clk,
    input  logic              i_Rst,
    input  logic              i_We,
    input  logic [ADDR_W-1:0] i_Waddr,
    input  logic [DATA_W-1:0] i_Wdata,
    input  logic [ADDR_W-1:0] i_Raddr,
    output logic [DATA_W-1:0] o_Rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge rx_Clk) begin
        if (i_We) begin
            mem[i_Waddr] <= i_Wdata;
        end
    end

    // Forward a write landing on the entry about to become the head.
    always_ff @(posedge rx_Clk) begin
        if (i_Rst) begin
            o_Rdata <= '0;
        end else if (i_We && (i_Waddr == i_Raddr)) begin
            o_Rdata <= i_Wdata;
        end else begin
            o_Rdata <= mem[i_Raddr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver with FWFT valid/ready output,
// fill level, full/empty status and sticky overflow flag.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              rx_Clk,
    input  logic              i_Rst,
    input  logic              i_RX_Valid,
    input  logic [DATA_W-1:0] i_RX_Byte,
    output logic [DATA_W-1:0] o_Data,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Full,
    output logic              o_Empty,
    output logic              o_Overflow,
    input  logic              i_Ovf_Clear
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic [ADDR_W:0]   count;
    logic              ovf;
    logic              wr;
    logic              rd;
    logic              drop;
    fifo_op_e          op;

    assign o_Count    = count;
    assign o_Full     = (count == DEPTH_C);
    assign o_Empty    = (count == '0);
    assign o_Valid    = ~o_Empty;
    assign o_Overflow = ovf;

    assign rd   = o_Valid & i_Ready;
    assign wr   = i_RX_Valid & ~i_Rst & (~o_Full | rd);
    assign drop = i_RX_Valid & o_Full & ~rd;
    assign op   = fifo_op_e'({wr, rd});

    assign rd_ptr_nxt = rd ? rd_ptr + ADDR_W'(1) : rd_ptr;

    always_ff @(posedge rx_Clk) begin
        if (i_Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            case (op)
                OP_WR:   count <= count + (ADDR_W+1)'(1);
                OP_RD:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (i_Ovf_Clear) begin
                ovf <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .rx_Clk  (rx_Clk),
        .i_Rst   (i_Rst),
        .i_We    (wr),
        .i_Waddr (wr_ptr),
        .i_Wdata (i_RX_Byte),
        .i_Raddr (i_Rst ? '0 : rd_ptr_nxt),
        .o_Rdata (o_Data)
    );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Byte buffer directly downstream of the UART receiver, clocked in the same rx_Clk domain. It captures each single-cycle valid/byte pulse from the receiver into a circular buffer. It presents the bytes in order to the consumer over a first-word-fall-through valid/ready interface. It reports fill level, full/empty status and a sticky overflow flag for bytes lost when the buffer is full.

Parameters:
ADDR_W, 4, log2 of buffer depth; DEPTH = 2**ADDR_W entries; legal range 1..8
DATA_W, 8, byte width; fixed at 8 for UART use

Ports:
rx_Clk  input  1  single clock, shared with the receiver
i_Rst  input  1  synchronous, active-high reset
i_RX_Valid  input  1  one-cycle pulse from receiver: i_RX_Byte is valid
i_RX_Byte  input  DATA_W  received byte
o_Data  output  DATA_W  head-of-queue byte, meaningful only when o_Valid=1
o_Valid  output  1  queue non-empty; o_Data holds the oldest byte
i_Ready  input  1  consumer accepts o_Data this cycle when o_Valid=1
o_Count  output  ADDR_W+1  number of stored bytes, 0..DEPTH
o_Full  output  1  o_Count == DEPTH
o_Empty  output  1  o_Count == 0
o_Overflow  output  1  sticky: at least one byte dropped since last clear
i_Ovf_Clear  input  1  clears o_Overflow

Behaviour:
- One clock, rx_Clk. Reset is synchronous and active-high (i_Rst); sampled on the rising edge of rx_Clk. All state updates on the rising edge.
- Reset values:
  - write pointer, read pointer and count = 0
  - o_Valid = 0, o_Empty = 1, o_Full = 0, o_Overflow = 0
  - o_Data = 0
  - storage array is not reset
- Reset mid-operation discards all queued bytes. An i_RX_Valid pulse in the reset cycle is ignored.
- Pointers are ADDR_W bits and wrap from DEPTH-1 to 0. Count is tracked separately as an ADDR_W+1-bit register. Full and empty are derived from count, never from pointer equality alone.
- Write event: wr = i_RX_Valid & (~o_Full | rd).
- Read event: rd = o_Valid & i_Ready.
- Write stores i_RX_Byte at the write pointer and advances it. Read advances the read pointer.
- Count update: +1 on wr only, -1 on rd only, unchanged when both or neither occur.
- Latency: a byte written into an empty queue appears on o_Data with o_Valid=1 in the cycle after the i_RX_Valid pulse. There is no same-cycle bypass.
- o_Data is the registered value of the head entry; it updates the cycle after a read or after a write into an empty queue.
- Full and read in the same cycle: the write is accepted, count stays DEPTH and no overflow is raised.
- Empty and write in the same cycle: no read can occur, since o_Valid=0.
- Overflow: i_RX_Valid with o_Full=1 and no read in the same cycle drops the byte. Stored data is unchanged and o_Overflow is set the next cycle.
- o_Overflow stays set until a cycle with i_Ovf_Clear=1 and no new drop. If a clear and a drop coincide, set wins.
- i_Ready while o_Valid=0 has no effect.
- o_Valid must not depend combinationally on i_Ready.
- The consumer may hold i_Ready low indefinitely. o_Data and o_Valid stay stable until accepted.
- All outputs are registered or decoded from registers only. There is no combinational path from i_RX_Valid to any output.

Decomposition:
- Shared UART package holds UART_DATA_W = 8, so receiver, FIFO and transmitter agree on byte width.
- One sub-module, uart_fifo_mem:
  - DEPTH x DATA_W register array
  - one synchronous write port
  - one registered read port, addressed by the next read pointer so the head stays current
- Pointer, count, flag and handshake logic stay in uart_rx_fifo.

Test Plan:
- Reset, then single pulse i_RX_Valid with 0xA5 -> next cycle o_Valid=1, o_Data=0xA5, o_Count=1. Then i_Ready=1 for one cycle -> o_Valid=0, o_Empty=1, o_Count=0.
- Write 0x00..0x0F, i_Ready=0, ADDR_W=4 -> o_Full=1, o_Count=16. Drain with i_Ready=1 -> bytes 0x00..0x0F in order, then o_Empty=1.
- Full queue plus write 0x77, no read -> byte dropped, o_Overflow=1, o_Count=16, head still 0x00. Pulse i_Ovf_Clear -> o_Overflow=0.
- Full queue, i_RX_Valid=1 with 0x88 and i_Ready=1 in the same cycle -> no overflow, o_Count=16. After draining, the last byte out is 0x88.
- Write 40 bytes with interleaved random i_Ready, never overfilling -> output sequence identical to input sequence. Pointers wrap at least twice.
- Queue holding 5 bytes, assert i_Rst for one cycle alongside an i_RX_Valid pulse -> o_Count=0, o_Valid=0, o_Overflow=0. The next write becomes the head.
